sata_xcvr_reconf_mc: RTL and testbench



---
 rtl/sata_xcvr_reconf_mc.sv | 181 ++++++++++++++++++
 tb/tb_sata_xcvr_reconf_mc.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sata_xcvr_reconf_mc.sv
// Multi-channel SATA gen reconfig sequencer: round-robin over per-channel requests, drives the MIF streamer.
// Job takes 22 cycles with an idle bus and a clear first poll; waitrequest holds each transfer stable.
module sata_xcvr_reconf_mc #(
  parameter int          CHANNELS   = 4,
  parameter logic [31:0] MIF_GEN1   = 32'h0000_0000,
  parameter logic [31:0] MIF_GEN2   = 32'h0000_0100,
  parameter logic [31:0] MIF_GEN3   = 32'h0000_0200,
  parameter int          POLL_LIMIT = 65535
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [CHANNELS-1:0]   cmd_reconfig,
  input  logic [2*CHANNELS-1:0] cmd_sata_gen,
  output logic [CHANNELS-1:0]   cmd_ready,
  output logic [CHANNELS-1:0]   cmd_error,
  output logic [6:0]            recfg_addr,
  output logic                  recfg_wreq,
  output logic [31:0]           recfg_wdat,
  output logic                  recfg_rreq,
  input  logic [31:0]           recfg_rdat,
  input  logic                  recfg_busy
);

  localparam int CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

  typedef enum logic [3:0] {
    IDLE, W_LCH, W_MODE, W_OFS0, W_BASE, W_CMD0, POLL0,
    W_OFS1, W_START, W_CMD1, POLL1, DONE
  } state_t;

  state_t                state, state_nxt;
  logic [CHANNELS-1:0]   pending;
  logic [2*CHANNELS-1:0] pend_gen;
  logic [CW-1:0]         rr_ptr, cur_ch, grant_ch;
  logic [1:0]            cur_gen, grant_gen;
  logic                  grant_vld;
  logic                  job_err;
  logic [15:0]           poll_cnt;
  logic                  bus_act, bus_rd;
  logic [6:0]            bus_addr;
  logic [31:0]           bus_wdat;
  logic                  xfer_done, poll_state, poll_busy, poll_expire;
  logic                  unused_rdat;

  assign unused_rdat = ^{recfg_rdat[31:9], recfg_rdat[7:0]};
  assign xfer_done   = (recfg_wreq | recfg_rreq) & ~recfg_busy;
  assign poll_state  = (state == POLL0) || (state == POLL1);
  assign poll_busy   = recfg_rdat[8];
  assign poll_expire = poll_state && xfer_done && poll_busy &&
                       (({1'b0, poll_cnt} + 17'd1) == 17'(POLL_LIMIT));

  // Descending scan so the smallest offset from rr_ptr wins.
  always_comb begin
    int idx;
    idx       = 0;
    grant_vld = 1'b0;
    grant_ch  = '0;
    grant_gen = 2'd0;
    for (int k = CHANNELS - 1; k >= 0; k--) begin
      idx = (int'(rr_ptr) + k) % CHANNELS;
      if (pending[idx]) begin
        grant_vld = 1'b1;
        grant_ch  = CW'(idx);
        grant_gen = pend_gen[2*idx +: 2];
      end
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (grant_vld) state_nxt = (grant_gen == 2'd0) ? DONE : W_LCH;
      W_LCH:   if (xfer_done) state_nxt = W_MODE;
      W_MODE:  if (xfer_done) state_nxt = W_OFS0;
      W_OFS0:  if (xfer_done) state_nxt = W_BASE;
      W_BASE:  if (xfer_done) state_nxt = W_CMD0;
      W_CMD0:  if (xfer_done) state_nxt = POLL0;
      POLL0:   if (xfer_done && (!poll_busy || poll_expire)) state_nxt = poll_busy ? DONE : W_OFS1;
      W_OFS1:  if (xfer_done) state_nxt = W_START;
      W_START: if (xfer_done) state_nxt = W_CMD1;
      W_CMD1:  if (xfer_done) state_nxt = POLL1;
      POLL1:   if (xfer_done && (!poll_busy || poll_expire)) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    bus_act  = 1'b1;
    bus_rd   = 1'b0;
    bus_addr = 7'h00;
    bus_wdat = 32'h0;
    case (state)
      W_LCH:   begin bus_addr = 7'h38; bus_wdat = 32'(cur_ch); end
      W_MODE:  begin bus_addr = 7'h3A; bus_wdat = 32'h0; end
      W_OFS0:  begin bus_addr = 7'h3B; bus_wdat = 32'h0; end
      W_BASE: begin
        bus_addr = 7'h3C;
        case (cur_gen)
          2'd1:    bus_wdat = MIF_GEN1;
          2'd2:    bus_wdat = MIF_GEN2;
          default: bus_wdat = MIF_GEN3;
        endcase
      end
      W_CMD0, W_CMD1: begin bus_addr = 7'h3A; bus_wdat = 32'h1; end
      W_OFS1:  begin bus_addr = 7'h3B; bus_wdat = 32'h1; end
      W_START: begin bus_addr = 7'h3C; bus_wdat = 32'h1; end
      POLL0, POLL1: begin bus_addr = 7'h3A; bus_rd = 1'b1; end
      default: bus_act = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pending    <= '0;
      pend_gen   <= '0;
      cmd_ready  <= '1;
      cmd_error  <= '0;
      rr_ptr     <= '0;
      cur_ch     <= '0;
      cur_gen    <= 2'd0;
      job_err    <= 1'b0;
      poll_cnt   <= 16'd0;
      recfg_wreq <= 1'b0;
      recfg_rreq <= 1'b0;
      recfg_addr <= 7'h00;
      recfg_wdat <= 32'h0;
    end else begin
      for (int i = 0; i < CHANNELS; i++) begin
        if (cmd_reconfig[i] && cmd_ready[i]) begin
          pending[i]          <= 1'b1;
          pend_gen[2*i +: 2]  <= cmd_sata_gen[2*i +: 2];
          cmd_ready[i]        <= 1'b0;
          cmd_error[i]        <= 1'b0;
        end
      end

      if (state == IDLE && grant_vld) begin
        cur_ch  <= grant_ch;
        cur_gen <= grant_gen;
        rr_ptr  <= CW'((int'(grant_ch) + 1) % CHANNELS);
        job_err <= (grant_gen == 2'd0);
      end

      // One request at a time; a new one is only raised once the previous has dropped.
      if (!recfg_wreq && !recfg_rreq) begin
        if (bus_act) begin
          recfg_wreq <= ~bus_rd;
          recfg_rreq <= bus_rd;
          recfg_addr <= bus_addr;
          recfg_wdat <= bus_wdat;
        end
      end else if (!recfg_busy) begin
        recfg_wreq <= 1'b0;
        recfg_rreq <= 1'b0;
      end

      if (!poll_state) begin
        poll_cnt <= 16'd0;
      end else if (xfer_done && poll_busy) begin
        poll_cnt <= poll_cnt + 16'd1;
      end
      if (poll_expire) job_err <= 1'b1;

      if (state == DONE) begin
        pending[cur_ch]   <= 1'b0;
        cmd_ready[cur_ch] <= 1'b1;
        if (job_err) cmd_error[cur_ch] <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_sata_xcvr_reconf_mc.sv
// Randomized bench for sata_xcvr_reconf_mc: expected bus transfers and job completions are queued at
// issue time from a reference model; a negedge monitor pops and compares.
module tb_sata_xcvr_reconf_mc;
  localparam int CH  = 4;
  localparam int LIM = 4;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic [CH-1:0]   cmd_reconfig = '0;
  logic [2*CH-1:0] cmd_sata_gen = '0;
  logic [CH-1:0]   cmd_ready, cmd_error;
  logic [6:0]      recfg_addr;
  logic            recfg_wreq, recfg_rreq;
  logic [31:0]     recfg_wdat;
  logic [31:0]     recfg_rdat = 32'h0;
  logic            recfg_busy = 1'b0;

  always #5 clk = ~clk;

  sata_xcvr_reconf_mc #(.CHANNELS(CH), .POLL_LIMIT(LIM)) dut (
    .clk(clk), .reset(reset),
    .cmd_reconfig(cmd_reconfig), .cmd_sata_gen(cmd_sata_gen),
    .cmd_ready(cmd_ready), .cmd_error(cmd_error),
    .recfg_addr(recfg_addr), .recfg_wreq(recfg_wreq), .recfg_wdat(recfg_wdat),
    .recfg_rreq(recfg_rreq), .recfg_rdat(recfg_rdat), .recfg_busy(recfg_busy)
  );

  typedef struct packed { logic rd; logic [6:0] addr; logic [31:0] dat; } xfer_t;
  typedef struct packed { logic [7:0] ch; logic err; } done_t;

  int      errors = 0, checks = 0;
  xfer_t   exp_x[$];
  done_t   exp_d[$];
  bit [CH-1:0] m_pend = '0;
  int      m_gen[CH];
  int      m_ptr = 0;
  bit      m_busy = 0;
  int      stall_n = 0;
  int      rd_cnt = 0;
  bit      rand_busy = 0, hold_base = 0, seen_start = 0;
  int      hold_cnt = 0, hold_len = 0, base_len = 0;
  bit      held = 0;
  xfer_t   held_x;
  logic [CH-1:0] prev_ready = '1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  function automatic logic [31:0] mif(input int g);
    if (g == 1) return 32'h0;
    if (g == 2) return 32'h100;
    return 32'h200;
  endfunction

  task automatic push_job(input int ch, input int g);
    int  reads;
    bit  tmo;
    if (g == 0) begin
      exp_d.push_back('{8'(ch), 1'b1});
      return;
    end
    tmo   = (stall_n >= LIM);
    reads = tmo ? LIM : stall_n + 1;
    exp_x.push_back('{1'b0, 7'h38, 32'(ch)});
    exp_x.push_back('{1'b0, 7'h3A, 32'h0});
    exp_x.push_back('{1'b0, 7'h3B, 32'h0});
    exp_x.push_back('{1'b0, 7'h3C, mif(g)});
    exp_x.push_back('{1'b0, 7'h3A, 32'h1});
    repeat (reads) exp_x.push_back('{1'b1, 7'h3A, 32'h0});
    if (!tmo) begin
      exp_x.push_back('{1'b0, 7'h3B, 32'h1});
      exp_x.push_back('{1'b0, 7'h3C, 32'h1});
      exp_x.push_back('{1'b0, 7'h3A, 32'h1});
      repeat (reads) exp_x.push_back('{1'b1, 7'h3A, 32'h0});
    end
    exp_d.push_back('{8'(ch), tmo});
  endtask

  // Round-robin service: first pending channel at or after the pointer.
  task automatic model_next();
    int c;
    m_busy = 0;
    for (int k = 0; k < CH; k++) begin
      c = (m_ptr + k) % CH;
      if (m_pend[c]) begin
        m_pend[c] = 0;
        m_ptr     = (c + 1) % CH;
        m_busy    = 1;
        push_job(c, m_gen[c]);
        break;
      end
    end
  endtask

  task automatic model_clear();
    exp_x.delete();
    exp_d.delete();
    m_pend = '0; m_ptr = 0; m_busy = 0; rd_cnt = 0;
  endtask

  // Leaves the caller 1 time unit after the accepting edge.
  task automatic issue(input logic [CH-1:0] mask, input logic [2*CH-1:0] gens);
    @(posedge clk); #1;
    cmd_reconfig = mask;
    cmd_sata_gen = gens;
    for (int i = 0; i < CH; i++)
      if (mask[i]) begin m_pend[i] = 1; m_gen[i] = int'(gens[2*i +: 2]); end
    if (!m_busy) model_next();
    @(posedge clk); #1;
    cmd_reconfig = '0;
    cmd_sata_gen = 8'($urandom);
  endtask

  task automatic wait_idle(input int maxc);
    int n = 0;
    while (!(&cmd_ready && !m_busy && m_pend == 0 && exp_d.size() == 0 && exp_x.size() == 0)
           && n < maxc) begin
      @(posedge clk); #1; n++;
    end
    chk("wait_idle_timeout", 64'(n >= maxc), 64'(0));
    if (n >= maxc) model_clear();
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    reset = 1;
    model_clear();
    repeat (2) @(posedge clk);
    #1 reset = 0;
  endtask

  always @(posedge clk) begin
    #1;
    if (hold_cnt > 0) begin
      recfg_busy = 1; hold_cnt--;
    end else if (hold_base && recfg_wreq && recfg_addr == 7'h3C && recfg_wdat == 32'h100) begin
      recfg_busy = 1; hold_cnt = 4; hold_base = 0;
    end else begin
      recfg_busy = rand_busy && ($urandom_range(3) == 0);
    end
  end

  always @(negedge clk) begin
    xfer_t cur;
    done_t d;
    if (reset) begin
      held = 0; hold_len = 0;
    end else begin
      if (recfg_wreq || recfg_rreq) begin
        cur = '{recfg_rreq, recfg_addr, recfg_rreq ? 32'h0 : recfg_wdat};
        if (held) chk("hold_stable", 64'(cur), 64'(held_x));
        hold_len++;
        if (recfg_busy) begin
          held = 1; held_x = cur;
          recfg_rdat = $urandom;
        end else begin
          chk("req_exclusive", 64'(recfg_wreq & recfg_rreq), 64'(0));
          if (exp_x.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_xfer: got %0h expected none", cur);
          end else begin
            chk("xfer", 64'(cur), 64'(exp_x.pop_front()));
          end
          if (cur.addr == 7'h3C && cur.dat == 32'h100) base_len = hold_len;
          if (cur.addr == 7'h3C && cur.dat == 32'h1 && !cur.rd) seen_start = 1;
          if (recfg_wreq) rd_cnt = 0;
          else begin
            recfg_rdat = ($urandom & 32'hFFFF_FEFF) | ((rd_cnt < stall_n) ? 32'h100 : 32'h0);
            rd_cnt++;
          end
          hold_len = 0; held = 0;
        end
      end else begin
        if (held) chk("req_held", 64'({recfg_wreq, recfg_rreq}), 64'(held_x.rd ? 2'b01 : 2'b10));
        held = 0; hold_len = 0;
      end
      for (int i = 0; i < CH; i++) begin
        if (cmd_ready[i] && !prev_ready[i]) begin
          if (exp_d.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_done: got ch %0d expected none", i);
          end else begin
            d = exp_d.pop_front();
            chk("done_ch", 64'(i), 64'(d.ch));
            chk("done_err", 64'(cmd_error[i]), 64'(d.err));
          end
          model_next();
        end
      end
    end
    prev_ready = cmd_ready;
  end

  initial begin
    #900us;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int n;
    logic [CH-1:0]   mask;
    logic [2*CH-1:0] gens;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", 64'(cmd_ready), 64'(4'hF));
    chk("rst_error", 64'(cmd_error), 64'(0));
    chk("rst_wreq", 64'(recfg_wreq), 64'(0));
    chk("rst_rreq", 64'(recfg_rreq), 64'(0));
    chk("rst_addr", 64'(recfg_addr), 64'(0));
    chk("rst_wdat", 64'(recfg_wdat), 64'(0));
    reset = 0;

    // Channel 2, gen 2, idle bus: latency to ready.
    issue(4'b0100, 8'b00_10_00_00);
    chk("ready_low_after_accept", 64'(cmd_ready[2]), 64'(0));
    n = 0;
    do begin @(posedge clk); #1; n++; end while (!cmd_ready[2] && n < 100);
    chk("latency_22", 64'(n), 64'(22));
    chk("ch2_no_error", 64'(cmd_error[2]), 64'(0));
    wait_idle(200);

    // Simultaneous ch0/ch3 from pointer 0, then ch1 during ch0's job.
    do_reset();
    issue(4'b1001, 8'b10_00_00_01);
    repeat (5) @(posedge clk);
    issue(4'b0010, 8'b00_00_11_00);
    wait_idle(500);

    // Waitrequest held 5 cycles on the MIF base write.
    base_len = 0; hold_base = 1;
    issue(4'b0001, 8'b00_00_00_10);
    wait_idle(300);
    chk("base_hold_len", 64'(base_len), 64'(6));

    // Busy bit stuck: timeout after LIM reads, then next accept clears the error.
    stall_n = 10;
    issue(4'b1000, 8'b01_00_00_00);
    wait_idle(300);
    chk("timeout_error", 64'(cmd_error[3]), 64'(1));
    stall_n = 0;
    issue(4'b1000, 8'b11_00_00_00);
    chk("error_cleared", 64'(cmd_error[3]), 64'(0));
    wait_idle(300);

    // Invalid generation: no bus traffic, fast error completion.
    issue(4'b0010, 8'b00_00_00_00);
    n = 0;
    while (!cmd_ready[1] && n < 10) begin @(posedge clk); #1; n++; end
    chk("gen0_within_3", 64'(n <= 3), 64'(1));
    chk("gen0_error", 64'(cmd_error[1]), 64'(1));
    wait_idle(50);

    // Reset during POLL1 with a read outstanding.
    stall_n = 3; seen_start = 0;
    issue(4'b0100, 8'b00_01_00_00);
    issue(4'b0010, 8'b00_00_01_00);
    n = 0;
    while (!(seen_start && recfg_rreq) && n < 300) begin @(posedge clk); #1; n++; end
    chk("reach_poll1", 64'(n < 300), 64'(1));
    reset = 1;
    @(posedge clk);
    @(negedge clk);
    chk("rst_mid_rreq", 64'(recfg_rreq), 64'(0));
    chk("rst_mid_ready", 64'(cmd_ready), 64'(4'hF));
    chk("rst_mid_error", 64'(cmd_error), 64'(0));
    model_clear();
    @(posedge clk); #1;
    reset = 0;
    issue(4'b1010, 8'b10_00_01_00);
    wait_idle(500);

    // Randomized batches.
    for (int b = 0; b < 20; b++) begin
      stall_n   = $urandom_range(0, 5);
      rand_busy = $urandom_range(0, 1) == 1;
      mask      = 4'($urandom_range(1, 15));
      gens      = 8'($urandom);
      issue(mask, gens);
      wait_idle(3000);
    end
    rand_busy = 0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
